// File: rtl/sdram_read_responder.sv
// Avalon-MM burst-read responder standing in for the HPS SDRAM f2h read port.
// Returns an address-derived, seed-keyed pattern with fixed latency and optional stalls.
module sdram_read_responder #(
    parameter int unsigned ADDRESS_BITS   = 29,
    parameter int unsigned BURST_BITS     = 8,
    parameter int unsigned LATENCY        = 4,
    parameter int unsigned CMD_DEPTH      = 4,
    parameter int unsigned LOG2_CMD_DEPTH = 2,
    parameter int unsigned STALL_PERIOD   = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDRESS_BITS-1:0] address,
    input  logic [BURST_BITS-1:0]   burstcount,
    input  logic                    read,
    output logic                    waitrequest,
    output logic [63:0]             readdata,
    output logic                    readdatavalid,
    input  logic                    stall_enable,
    input  logic [31:0]             pattern_seed,
    output logic [31:0]             bursts_served,
    output logic                    error
);

    localparam int unsigned AGE_BITS   = $clog2(LATENCY + 1);
    localparam int unsigned STALL_BITS = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

    localparam logic [AGE_BITS-1:0]       AGE_READY  = AGE_BITS'(LATENCY);
    localparam logic [AGE_BITS-1:0]       AGE_PUSH   = AGE_BITS'(1);
    localparam logic [STALL_BITS-1:0]     STALL_LAST = (STALL_PERIOD == 0) ? '0 : STALL_BITS'(STALL_PERIOD - 1);
    localparam logic [LOG2_CMD_DEPTH:0]   DEPTH_FULL = (LOG2_CMD_DEPTH + 1)'(CMD_DEPTH);
    localparam logic [BURST_BITS-1:0]     ONE_BEAT   = BURST_BITS'(1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t state;

    logic [ADDRESS_BITS-1:0]   cmd_addr  [CMD_DEPTH];
    logic [BURST_BITS-1:0]     cmd_count [CMD_DEPTH];
    logic [AGE_BITS-1:0]       cmd_age   [CMD_DEPTH];
    logic [LOG2_CMD_DEPTH-1:0] wr_ptr;
    logic [LOG2_CMD_DEPTH-1:0] rd_ptr;
    logic [LOG2_CMD_DEPTH:0]   occupancy;
    logic [STALL_BITS-1:0]     stall_cnt;
    logic [BURST_BITS-1:0]     beat_idx;

    logic                    full;
    logic                    stall_now;
    logic                    accept;
    logic                    head_ready;
    logic [ADDRESS_BITS-1:0] head_addr;
    logic [BURST_BITS-1:0]   head_count;
    logic [ADDRESS_BITS-1:0] beat_addr;
    logic [31:0]             beat_word;
    logic [63:0]             beat_data;
    logic                    emit;
    logic                    pop;

    assign full        = (occupancy == DEPTH_FULL);
    assign stall_now   = stall_enable && (STALL_PERIOD != 0) && (stall_cnt == STALL_LAST);
    assign waitrequest = reset || full || stall_now;
    assign accept      = read && !waitrequest;

    assign head_addr  = cmd_addr[rd_ptr];
    assign head_count = cmd_count[rd_ptr];
    assign head_ready = (occupancy != '0) && (cmd_age[rd_ptr] == AGE_READY);

    // beat_idx stays 0 in IDLE, so the same adder serves the first beat of a burst
    assign beat_addr = head_addr + ADDRESS_BITS'(beat_idx);
    assign beat_word = 32'(beat_addr);
    assign beat_data = {beat_word ^ pattern_seed, ~beat_word ^ pattern_seed};

    always_comb begin
        emit = 1'b0;
        pop  = 1'b0;
        case (state)
            IDLE: begin
                if (head_ready) begin
                    if (head_count == '0) begin
                        pop = 1'b1;
                    end else begin
                        emit = 1'b1;
                        pop  = (head_count == ONE_BEAT);
                    end
                end
            end
            BURST: begin
                emit = 1'b1;
                pop  = (beat_idx == head_count - ONE_BEAT);
            end
            default: begin
                emit = 1'b0;
                pop  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            cmd_addr[wr_ptr]  <= address;
            cmd_count[wr_ptr] <= burstcount;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            beat_idx      <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occupancy     <= '0;
            stall_cnt     <= '0;
            readdatavalid <= 1'b0;
            readdata      <= '0;
            bursts_served <= '0;
            error         <= 1'b0;
            for (int unsigned i = 0; i < CMD_DEPTH; i++) begin
                cmd_age[i] <= '0;
            end
        end else begin
            if (STALL_PERIOD != 0) begin
                stall_cnt <= (stall_cnt == STALL_LAST) ? '0 : stall_cnt + 1'b1;
            end

            // every slot ages each cycle; a push below overrides its own slot
            for (int unsigned i = 0; i < CMD_DEPTH; i++) begin
                if (cmd_age[i] != AGE_READY) begin
                    cmd_age[i] <= cmd_age[i] + 1'b1;
                end
            end

            if (accept) begin
                cmd_age[wr_ptr] <= AGE_PUSH;
                wr_ptr          <= wr_ptr + 1'b1;
                if (burstcount == '0) begin
                    error <= 1'b1;
                end
            end

            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                if (head_count != '0) begin
                    bursts_served <= bursts_served + 1'b1;
                end
            end

            case ({accept, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase

            readdatavalid <= emit;
            readdata      <= emit ? beat_data : '0;

            case (state)
                IDLE: begin
                    if (emit && !pop) begin
                        state    <= BURST;
                        beat_idx <= ONE_BEAT;
                    end
                end
                BURST: begin
                    if (pop) begin
                        state    <= IDLE;
                        beat_idx <= '0;
                    end else begin
                        beat_idx <= beat_idx + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    beat_idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_read_responder.sv
// Randomized and directed bench for sdram_read_responder against a schedule-based reference.
module tb_sdram_read_responder;

    localparam int unsigned LAT   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned SPER  = 3;

    logic        clock;
    logic        reset;
    logic [28:0] address;
    logic [7:0]  burstcount;
    logic        read;
    logic        waitrequest;
    logic [63:0] readdata;
    logic        readdatavalid;
    logic        stall_enable;
    logic [31:0] pattern_seed;
    logic [31:0] bursts_served;
    logic        error;

    sdram_read_responder #(
        .ADDRESS_BITS  (29),
        .BURST_BITS    (8),
        .LATENCY       (LAT),
        .CMD_DEPTH     (DEPTH),
        .LOG2_CMD_DEPTH(2),
        .STALL_PERIOD  (SPER)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .address      (address),
        .burstcount   (burstcount),
        .read         (read),
        .waitrequest  (waitrequest),
        .readdata     (readdata),
        .readdatavalid(readdatavalid),
        .stall_enable (stall_enable),
        .pattern_seed (pattern_seed),
        .bursts_served(bursts_served),
        .error        (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: each command's beats are scheduled at acceptance from
    // start = max(accept_edge + LATENCY, engine_free_edge).
    typedef struct {
        int unsigned at;
        logic [28:0] addr;
    } beat_t;

    typedef struct {
        logic [28:0] addr;
        logic [7:0]  bc;
        int unsigned gap;
    } cmd_t;

    beat_t       beat_q[$];
    int unsigned pop_q[$];
    int unsigned done_q[$];
    cmd_t        cmd_q[$];

    int unsigned edge_n   = 0;
    int unsigned scnt     = 0;
    int unsigned f_last   = 0;
    int unsigned m_served = 0;
    bit          m_error  = 0;
    int unsigned m_beats  = 0;
    int unsigned dut_beats = 0;
    int unsigned wait_seen = 0;
    logic [31:0] last_hi  = '0;

    task automatic model_accept(input int unsigned t, input logic [28:0] a, input logic [7:0] bc);
        int unsigned s;
        beat_t b;
        s = (t + LAT > f_last) ? t + LAT : f_last;
        if (bc == 0) begin
            m_error = 1;
            pop_q.push_back(s);
            f_last = s + 1;
        end else begin
            for (int unsigned i = 0; i < bc; i++) begin
                b.at   = s + i;
                b.addr = 29'(a + 29'(i));
                beat_q.push_back(b);
            end
            pop_q.push_back(s + bc - 1);
            done_q.push_back(s + bc - 1);
            f_last = s + bc;
        end
    endtask

    task automatic step(output bit accepted);
        bit          exp_wait;
        bit          exp_valid;
        logic [63:0] exp_data;
        logic [31:0] a;
        beat_t       b;
        @(negedge clock);
        exp_wait = reset || (pop_q.size() == DEPTH) || (stall_enable && scnt == SPER - 1);
        check("waitrequest", waitrequest, exp_wait);
        if (read && waitrequest) wait_seen++;
        accepted = read && !exp_wait;
        @(posedge clock);
        edge_n++;
        exp_valid = 0;
        exp_data  = '0;
        if (reset) begin
            beat_q.delete();
            pop_q.delete();
            done_q.delete();
            scnt     = 0;
            f_last   = 0;
            m_served = 0;
            m_error  = 0;
        end else begin
            scnt = (scnt + 1) % SPER;
            if (accepted) model_accept(edge_n, address, burstcount);
            while (pop_q.size() > 0 && pop_q[0] <= edge_n) void'(pop_q.pop_front());
            while (done_q.size() > 0 && done_q[0] <= edge_n) begin
                void'(done_q.pop_front());
                m_served++;
            end
            if (beat_q.size() > 0 && beat_q[0].at == edge_n) begin
                b = beat_q.pop_front();
                a = 32'(b.addr);
                exp_valid = 1;
                exp_data  = {a ^ pattern_seed, ~a ^ pattern_seed};
                m_beats++;
            end
        end
        #1;
        check("readdatavalid", readdatavalid, exp_valid);
        check("readdata", readdata, exp_data);
        check("bursts_served", bursts_served, m_served);
        check("error", error, m_error);
        if (readdatavalid === 1'b1) begin
            dut_beats++;
            last_hi = readdata[63:32];
        end
    endtask

    task automatic do_reset(input int unsigned n);
        bit acc;
        read  = 0;
        reset = 1;
        repeat (n) step(acc);
        reset = 0;
    endtask

    // Drives cmd_q holding read through waitrequest; optionally resets after reset_at beats.
    task automatic run_cmds(input int unsigned reset_at);
        bit          acc;
        int unsigned gap_cnt;
        int unsigned budget;
        int unsigned start_beats;
        gap_cnt     = (cmd_q.size() > 0) ? cmd_q[0].gap : 0;
        budget      = 0;
        start_beats = m_beats;
        while ((cmd_q.size() > 0 || read || beat_q.size() > 0 || pop_q.size() > 0) && budget < 3000) begin
            budget++;
            if (!read && cmd_q.size() > 0) begin
                if (gap_cnt == 0) begin
                    address    = cmd_q[0].addr;
                    burstcount = cmd_q[0].bc;
                    read       = 1;
                end else begin
                    gap_cnt--;
                end
            end
            step(acc);
            if (acc) begin
                void'(cmd_q.pop_front());
                read = 0;
                if (cmd_q.size() > 0) gap_cnt = cmd_q[0].gap;
            end
            if (reset_at != 0 && m_beats - start_beats == reset_at) begin
                cmd_q.delete();
                do_reset(1);
                break;
            end
        end
        check("drain_budget", budget < 3000, 1);
    endtask

    int unsigned b0;
    int unsigned exp_served;
    int unsigned exp_beats;
    cmd_t        c;

    initial begin
        reset        = 1;
        read         = 0;
        address      = '0;
        burstcount   = '0;
        stall_enable = 0;
        pattern_seed = '0;
        do_reset(3);

        // 1: single burst, seed 0
        cmd_q.push_back('{29'h100, 8'd4, 0});
        b0 = dut_beats;
        run_cmds(0);
        check("t1_beats", dut_beats - b0, 4);
        check("t1_served", bursts_served, 1);

        // 2: six held back-to-back bursts fill the command FIFO
        do_reset(1);
        for (int unsigned k = 0; k < 6; k++) cmd_q.push_back('{29'(32'h200 + 2 * k), 8'd2, 0});
        b0 = dut_beats;
        wait_seen = 0;
        run_cmds(0);
        check("t2_beats", dut_beats - b0, 12);
        check("t2_served", bursts_served, 6);
        check("t2_backpressure", wait_seen > 0, 1);

        // 3: periodic stalls with held requests
        do_reset(1);
        stall_enable = 1;
        for (int unsigned k = 0; k < 5; k++) cmd_q.push_back('{29'(32'h400 + 8 * k), 8'd3, k % 2});
        b0 = dut_beats;
        wait_seen = 0;
        run_cmds(0);
        check("t3_beats", dut_beats - b0, 15);
        check("t3_served", bursts_served, 5);
        check("t3_stalled", wait_seen > 0, 1);
        stall_enable = 0;

        // 4: address wrap with seed
        do_reset(1);
        pattern_seed = 32'hA5A5_A5A5;
        cmd_q.push_back('{29'h1FFF_FFFF, 8'd2, 0});
        b0 = dut_beats;
        run_cmds(0);
        check("t4_beats", dut_beats - b0, 2);
        check("t4_wrap_hi", last_hi, 32'hA5A5_A5A5);

        // 5: zero-length burst then a single beat
        do_reset(1);
        pattern_seed = '0;
        cmd_q.push_back('{29'h8, 8'd0, 0});
        cmd_q.push_back('{29'h10, 8'd1, 0});
        b0 = dut_beats;
        run_cmds(0);
        check("t5_beats", dut_beats - b0, 1);
        check("t5_error", error, 1);
        check("t5_served", bursts_served, 1);

        // 6: reset three beats into an 8-beat burst, then a fresh burst
        do_reset(1);
        cmd_q.push_back('{29'h300, 8'd8, 0});
        run_cmds(3);
        check("t6_served_rst", bursts_served, 0);
        check("t6_valid_rst", readdatavalid, 0);
        cmd_q.push_back('{29'h20, 8'd2, 1});
        b0 = dut_beats;
        run_cmds(0);
        check("t6_beats", dut_beats - b0, 2);
        check("t6_served", bursts_served, 1);

        // random traffic, with and without stalls
        for (int unsigned r = 0; r < 2; r++) begin
            do_reset(1);
            stall_enable = r[0];
            pattern_seed = $urandom();
            exp_served   = 0;
            exp_beats    = 0;
            for (int unsigned k = 0; k < 30; k++) begin
                c.addr = 29'($urandom());
                c.bc   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
                c.gap  = $urandom_range(0, 3);
                if (c.bc != 0) exp_served++;
                exp_beats += c.bc;
                cmd_q.push_back(c);
            end
            b0 = dut_beats;
            run_cmds(0);
            check("rnd_beats", dut_beats - b0, exp_beats);
            check("rnd_served", bursts_served, exp_served);
        end
        stall_enable = 0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
